// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sample width, saturation limits and
// the shift-with-saturation helper used by the output stage.
package fir_pkg;

    localparam int DATA_W  = 16;
    localparam int WIDE_W  = DATA_W + 7;
    localparam int PHASE_W = 8;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_W-1:0] value;
        logic                     sat;
    } sat_res_t;

    // Left-shift at full width so no bits are lost before the range test.
    function automatic sat_res_t sat_shift(input logic signed [DATA_W-1:0] din,
                                           input logic [2:0]               shift);
        logic signed [WIDE_W-1:0] wide;
        logic signed [WIDE_W-1:0] wide_max;
        logic signed [WIDE_W-1:0] wide_min;
        sat_res_t                 res;
        wide     = WIDE_W'(din) <<< shift;
        wide_max = WIDE_W'(SAT_MAX);
        wide_min = WIDE_W'(SAT_MIN);
        if (wide > wide_max) begin
            res.value = SAT_MAX;
            res.sat   = 1'b1;
        end else if (wide < wide_min) begin
            res.value = SAT_MIN;
            res.sat   = 1'b1;
        end else begin
            res.value = wide[DATA_W-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered empty/full and a registered
// head output that holds its last value when the FIFO drains.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_push_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_dout;

    logic             w_do_push;
    logic             w_do_pop;
    logic             w_last;
    logic [AW:0]      w_rd_ptr_inc;
    logic [AW:0]      w_wr_ptr_next;
    logic [AW:0]      w_rd_ptr_next;

    assign w_do_pop      = i_pop & ~r_empty;
    assign w_do_push     = i_push & (~r_full | i_pop);
    assign w_rd_ptr_inc  = r_rd_ptr + 1'b1;
    assign w_last        = (w_rd_ptr_inc == r_wr_ptr);
    assign w_wr_ptr_next = r_wr_ptr + (AW+1)'(w_do_push);
    assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
            r_full   <= (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]) &&
                        (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]);
            // Prefetch the next head; the slot at rd+1 is never the one being written
            // unless it is the write itself, which is then forwarded.
            if (w_do_pop) begin
                if (!w_last) begin
                    r_dout <= r_mem[w_rd_ptr_inc[AW-1:0]];
                end else if (w_do_push) begin
                    r_dout <= i_data;
                end
            end else if (r_empty && w_do_push) begin
                r_dout <= i_data;
            end
        end
    end

    assign o_data      = r_dout;
    assign o_empty     = r_empty;
    assign o_push_drop = i_push & r_full & ~i_pop;

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: decimate strobed samples, apply shift gain with saturation,
// buffer in a FIFO and present them on a valid/ready stream with drop statistics.
module fir_out_decim #(
    parameter int DATA_W     = 16,
    parameter int DECIM      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_stb,
    input  logic [DATA_W-1:0] filter_out,
    input  logic [2:0]        gain_shift,
    input  logic              clr_stats,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              sat_flag,
    output logic [CNT_W-1:0]  ovf_cnt
);
    import fir_pkg::*;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

    logic [PHASE_W-1:0] r_phase;
    logic [DATA_W-1:0]  r_y;
    logic               r_y_vld;
    logic               r_sat_flag;
    logic [CNT_W-1:0]   r_ovf_cnt;

    logic               w_keep;
    sat_res_t           w_sat;
    logic               w_empty;
    logic               w_push_drop;

    assign w_keep = sample_stb && (r_phase == '0);
    assign w_sat  = sat_shift(filter_out, gain_shift);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_y     <= '0;
            r_y_vld <= 1'b0;
        end else begin
            if (sample_stb) begin
                r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
            end
            r_y_vld <= w_keep;
            if (w_keep) begin
                r_y <= w_sat.value;
            end
        end
    end

    // Clear takes priority, so an event coinciding with it is not recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (clr_stats) begin
            r_sat_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_keep && w_sat.sat) begin
                r_sat_flag <= 1'b1;
            end
            if (w_push_drop && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_y_vld),
        .i_data      (r_y),
        .i_pop       (m_ready),
        .o_data      (m_data),
        .o_empty     (w_empty),
        .o_push_drop (w_push_drop)
    );

    assign m_valid  = ~w_empty;
    assign sat_flag = r_sat_flag;
    assign ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_fir_out_decim.sv
// Randomized and directed stimulus against a queue-based behavioural model with a
// scoreboard monitor sampling DUT outputs on the falling edge.
module tb_fir_out_decim;
    localparam int DATA_W = 16;
    localparam int DECIM  = 6;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_stb;
    logic [DATA_W-1:0] filter_out;
    logic [2:0]        gain_shift;
    logic              clr_stats;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              sat_flag;
    logic [CNT_W-1:0]  ovf_cnt;

    always #5 clk = ~clk;

    fir_out_decim #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .filter_out (filter_out),
        .gain_shift (gain_shift),
        .clr_stats  (clr_stats),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .sat_flag   (sat_flag),
        .ovf_cnt    (ovf_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int mq[$];          // expected FIFO contents, head first
    int seen[$];        // samples actually accepted from the DUT
    bit st_vld;
    int st_val;
    int strobes;
    int m_ovf;
    bit m_sat;
    int shown;
    bit live = 1'b0;
    bit pop_m;
    bit drop_m;
    bit sat_ev;
    int gain_val;
    bit gain_sat;

    function automatic void ref_gain(input int sd, input int g, output int val, output bit sat);
        int v;
        v   = sd * (1 << g);
        sat = 1'b0;
        if (v > 32767) begin
            v   = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v   = -32768;
            sat = 1'b1;
        end
        val = v & 32'hFFFF;
    endfunction

    always @(posedge clk) begin
        live = 1'b1;
        if (!rst_n) begin
            mq.delete();
            st_vld  = 1'b0;
            strobes = 0;
            m_ovf   = 0;
            m_sat   = 1'b0;
            shown   = 0;
        end else begin
            pop_m  = (mq.size() > 0) && m_ready;
            drop_m = st_vld && (mq.size() >= DEPTH) && !pop_m;
            if (pop_m) void'(mq.pop_front());
            if (st_vld && !drop_m) mq.push_back(st_val);
            if (clr_stats) m_ovf = 0;
            else if (drop_m && m_ovf < CNT_MAX) m_ovf++;
            sat_ev = 1'b0;
            st_vld = 1'b0;
            if (sample_stb) begin
                if (strobes % DECIM == 0) begin
                    ref_gain(int'($signed(filter_out)), int'(gain_shift), gain_val, gain_sat);
                    st_vld = 1'b1;
                    st_val = gain_val;
                    sat_ev = gain_sat;
                end
                strobes++;
            end
            if (clr_stats) m_sat = 1'b0;
            else if (sat_ev) m_sat = 1'b1;
            if (mq.size() > 0) shown = mq[0];
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (live) begin
            check("m_valid", int'(m_valid), int'(mq.size() > 0));
            if (m_valid && m_ready && mq.size() > 0) begin
                check("accept_data", int'(m_data), mq[0]);
                seen.push_back(int'(m_data));
            end else begin
                check("m_data_hold", int'(m_data), shown);
            end
            check("ovf_cnt", int'(ovf_cnt), m_ovf);
            check("sat_flag", int'(sat_flag), int'(m_sat));
        end
    end

    function automatic int seen_at(input int k);
        return (k < seen.size()) ? seen[k] : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int d, input int g);
        sample_stb = 1'b1;
        filter_out = d[DATA_W-1:0];
        gain_shift = g[2:0];
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic send_kept(input int d, input int g);
        strobe(d, g);
        repeat (DECIM - 1) strobe(int'($urandom), int'($urandom_range(0, 7)));
    endtask

    initial begin
        rst_n      = 1'b0;
        sample_stb = 1'b0;
        filter_out = '0;
        gain_shift = '0;
        clr_stats  = 1'b0;
        m_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_data", int'(m_data), 0);
        check("reset_ovf", int'(ovf_cnt), 0);
        tick();

        // 1: DECIM=6, unity gain, inputs 1..12 -> 1 and 7
        seen.delete();
        m_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            strobe(i, 0);
            tick();
        end
        repeat (4) tick();
        check("t1_count", seen.size(), 2);
        check("t1_first", seen_at(0), 1);
        check("t1_second", seen_at(1), 7);

        // 2: gain 3 with and without saturation
        seen.delete();
        send_kept(16'h0100, 3);
        @(negedge clk);
        check("t2_no_sat", int'(sat_flag), 0);
        tick();
        send_kept(16'h1000, 3);
        @(negedge clk);
        check("t2_sat", int'(sat_flag), 1);
        tick();
        send_kept(16'hF000, 3);
        repeat (4) tick();
        check("t2_a", seen_at(0), 16'h0800);
        check("t2_b", seen_at(1), 16'h7FFF);
        check("t2_c", seen_at(2), 16'h8000);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;

        // 3: fill with no reads, two drops, then drain in order
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) send_kept(100 + k, 0);
        repeat (3) tick();
        @(negedge clk);
        check("t3_ovf", int'(ovf_cnt), 2);
        check("t3_full_valid", int'(m_valid), 1);
        tick();
        seen.delete();
        m_ready = 1'b1;
        repeat (12) tick();
        m_ready = 1'b0;
        check("t3_drain_count", seen.size(), 8);
        for (int k = 0; k < 8; k++) check("t3_order", seen_at(k), 100 + k);

        // 4: full FIFO, write coincides with a read
        seen.delete();
        for (int k = 0; k < 8; k++) send_kept(200 + k, 0);
        repeat (3) tick();
        strobe(300, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (DECIM - 1) strobe(int'($urandom), 0);
        repeat (3) tick();
        @(negedge clk);
        check("t4_ovf_same", int'(ovf_cnt), 2);
        tick();
        m_ready = 1'b1;
        repeat (12) tick();
        m_ready = 1'b0;
        check("t4_total", seen.size(), 9);
        check("t4_last", seen_at(8), 300);

        // 5: reset with 3 entries buffered and mid-phase
        for (int k = 0; k < 3; k++) send_kept(400 + k, 0);
        strobe(1, 0);
        strobe(2, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_valid", int'(m_valid), 0);
        check("t5_ovf", int'(ovf_cnt), 0);
        tick();
        seen.delete();
        m_ready = 1'b1;
        strobe(55, 0);
        repeat (4) tick();
        check("t5_kept", seen_at(0), 55);
        repeat (DECIM - 1) strobe(int'($urandom), 0);

        // 6: counter saturation, then clear together with a drop
        m_ready = 1'b0;
        send_kept(16'h4000, 7);
        for (int k = 0; k < 7 + 300; k++) send_kept(int'($urandom), int'($urandom_range(0, 7)));
        repeat (3) tick();
        @(negedge clk);
        check("t6_ovf_sat", int'(ovf_cnt), CNT_MAX);
        check("t6_sat_flag", int'(sat_flag), 1);
        tick();
        strobe(16'h4000, 7);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        @(negedge clk);
        check("t6_clr_ovf", int'(ovf_cnt), 0);
        check("t6_clr_sat", int'(sat_flag), 0);
        tick();
        repeat (DECIM - 1) strobe(int'($urandom), 0);
        m_ready = 1'b1;
        repeat (12) tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            sample_stb = ($urandom_range(0, 2) != 0);
            filter_out = DATA_W'($urandom);
            gain_shift = 3'($urandom_range(0, 7));
            m_ready    = ($urandom_range(0, 9) < 6);
            clr_stats  = ($urandom_range(0, 63) == 0);
            rst_n      = ($urandom_range(0, 799) != 0);
            tick();
        end
        sample_stb = 1'b0;
        clr_stats  = 1'b0;
        rst_n      = 1'b1;
        m_ready    = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
